// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle joining the echo path, the report sender and the UART transmitter
// to the TX arbiter. The arbiter uses the slave view; the surrounding logic uses master.
interface uart_tx_arbiter_if #(
    parameter int ECHO_DEPTH = 8
);
    localparam int LVL_W = $clog2(ECHO_DEPTH) + 1;

    logic             i_echo_valid;
    logic [7:0]       i_echo_data;
    logic             i_rpt_valid;
    logic [7:0]       i_rpt_data;
    logic             i_rpt_last;
    logic             o_rpt_ready;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             i_tx_busy;
    logic             o_grant_rpt;
    logic [LVL_W-1:0] o_echo_level;
    logic             o_echo_ovf;
    logic             i_ovf_clr;
    logic             o_rpt_abort;

    modport slave (
        input  i_echo_valid, i_echo_data, i_rpt_valid, i_rpt_data, i_rpt_last,
        input  i_tx_busy, i_ovf_clr,
        output o_rpt_ready, o_tx_data, o_tx_start, o_grant_rpt, o_echo_level,
        output o_echo_ovf, o_rpt_abort
    );

    modport master (
        output i_echo_valid, i_echo_data, i_rpt_valid, i_rpt_data, i_rpt_last,
        output i_tx_busy, i_ovf_clr,
        input  o_rpt_ready, o_tx_data, o_tx_start, o_grant_rpt, o_echo_level,
        input  o_echo_ovf, o_rpt_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX channel between buffered echo bytes and multi-byte report messages,
// with round-robin arbitration at message boundaries and a gap timeout on report locks.
module uart_tx_arbiter #(
    parameter int         ECHO_DEPTH  = 8,
    parameter logic [7:0] FILTER_0    = 8'h70,
    parameter logic [7:0] FILTER_1    = 8'h50,
    parameter int         RPT_GAP_MAX = 4096
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(ECHO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = $clog2(RPT_GAP_MAX + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(ECHO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RPT_GAP_MAX - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_RGAP} state_e;

    state_e           state_q, state_d;
    logic             grant_rpt_q, grant_rpt_d;
    logic             rr_rpt_q, rr_rpt_d;
    logic             last_q, last_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mem_q [ECHO_DEPTH];

    logic push_req, push_ok, pop, full, echo_req;
    logic tx_start, rpt_ready, rpt_abort;

    // Echo FIFO: filtered bytes never enter; a pop frees the slot for a same-cycle push.
    always_comb begin
        push_req = bus.i_echo_valid && (bus.i_echo_data != FILTER_0)
                   && (bus.i_echo_data != FILTER_1);
        pop      = (state_q == S_ISSUE) && !grant_rpt_q;
        full     = (level_q == FULL_LVL);
        push_ok  = push_req && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        if (bus.i_ovf_clr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q | (push_req && !push_ok);
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        grant_rpt_d = grant_rpt_q;
        rr_rpt_d    = rr_rpt_q;
        last_d      = last_q;
        gap_d       = gap_q;
        tx_data_d   = tx_data_q;
        tx_start    = 1'b0;
        rpt_ready   = 1'b0;
        rpt_abort   = 1'b0;
        echo_req    = (level_q != '0);
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_rpt_valid && (!echo_req || !rr_rpt_q)) begin
                    grant_rpt_d = 1'b1;
                    state_d     = S_ISSUE;
                end else if (echo_req) begin
                    grant_rpt_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_start  = 1'b1;
                rpt_ready = grant_rpt_q;
                tx_data_d = grant_rpt_q ? bus.i_rpt_data : mem_q[rd_ptr_q];
                last_d    = grant_rpt_q && bus.i_rpt_last;
                state_d   = S_ARM;
            end
            S_ARM: state_d = S_WAIT;
            S_WAIT: begin
                if (!bus.i_tx_busy) begin
                    if (!grant_rpt_q || last_q) begin
                        grant_rpt_d = 1'b0;
                        rr_rpt_d    = grant_rpt_q;
                        state_d     = S_IDLE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_RGAP;
                    end
                end
            end
            S_RGAP: begin
                if (bus.i_rpt_valid) begin
                    state_d = S_ISSUE;
                end else if (gap_q == GAP_LAST) begin
                    rpt_abort   = 1'b1;
                    grant_rpt_d = 1'b0;
                    rr_rpt_d    = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_rpt_q <= 1'b0;
            rr_rpt_q    <= 1'b0;
            last_q      <= 1'b0;
            gap_q       <= '0;
            tx_data_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_rpt_q <= grant_rpt_d;
            rr_rpt_q    <= rr_rpt_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            tx_data_q   <= tx_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: storage is not reset; the cleared pointers and level make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= bus.i_echo_data;
    end

    assign bus.o_tx_start   = tx_start;
    assign bus.o_tx_data    = tx_start ? tx_data_d : tx_data_q;
    assign bus.o_rpt_ready  = rpt_ready;
    assign bus.o_rpt_abort  = rpt_abort;
    assign bus.o_grant_rpt  = grant_rpt_q;
    assign bus.o_echo_level = level_q;
    assign bus.o_echo_ovf   = ovf_q;
endmodule
